// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module : switch_pkg
// Shared types and defaults for the DIP-switch debouncer.
// Rev    : 1.0
// ============================================================================
package switch_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  localparam int DEBOUNCE_DEFAULT = 240000;
  localparam int SW_WIDTH         = 4;

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module : debounce_bit
// One switch bit: synchroniser chain, two-state debounce FSM, change pulse.
// Rev    : 1.0
// ============================================================================
module debounce_bit
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable,
  output logic change_pulse,
  output logic change_next
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   pulse_q, pulse_d;
  logic                   w_sync;

  assign w_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (w_sync != stable_q) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PENDING: begin
        // A sample matching the stable value is a bounce: drop the count.
        if (w_sync == stable_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = w_sync;
          pulse_d  = 1'b1;
          state_d  = ST_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign stable       = stable_q;
  assign change_pulse = pulse_q;
  // Next-cycle pulse lets the parent register its strobe in step with stable.
  assign change_next  = pulse_d;

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module : switch_debouncer
// Synchronises and debounces the DIP-switch bus; emits a change strobe/mask.
// Option : SW_ACTIVE_LOW_EN inverts sw_raw ahead of the synchroniser.
// Rev    : 1.0
// ============================================================================
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s,
  output logic             changed,
  output logic [WIDTH-1:0] change_mask
);

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_next;
  logic             changed_q, changed_d;

`ifdef SW_ACTIVE_LOW_EN
  assign w_raw = ~sw_raw;
`else
  assign w_raw = sw_raw;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (w_raw[i]),
      .stable       (s[i]),
      .change_pulse (change_mask[i]),
      .change_next  (w_next[i])
    );
  end

  always_comb begin
    changed_d = |w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module : tb_switch_debouncer
// Directed and random stimulus for switch_debouncer against a window model.
// Rev    : 1.0
// ============================================================================
module tb_switch_debouncer;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int LAT  = SYNC + DEB + 1;
`ifdef SW_ACTIVE_LOW_EN
  localparam logic [W-1:0] INV = 4'hF;
`else
  localparam logic [W-1:0] INV = 4'h0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] s;
  logic         changed;
  logic [W-1:0] change_mask;

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .s           (s),
    .changed     (changed),
    .change_mask (change_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a bit of s flips once the last DEB+1 synchronised samples all
  // disagree with it; the synchroniser is a plain SYNC-deep delay line.
  logic [W-1:0] pipe [SYNC];
  logic [W-1:0] win [$];
  logic [W-1:0] m_s    = '0;
  logic [W-1:0] m_mask = '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC; k++) pipe[k] = '0;
      win.delete();
      m_s    = '0;
      m_mask = '0;
    end else begin
      win.push_back(pipe[SYNC-1]);
      if (win.size() > DEB + 1) void'(win.pop_front());
      m_mask = '0;
      if (win.size() == DEB + 1) begin
        for (int b = 0; b < W; b++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][b] == m_s[b]) all_diff = 1'b0;
          m_mask[b] = all_diff;
        end
      end
      m_s = m_s ^ m_mask;
      for (int k = SYNC - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = sw_raw ^ INV;
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      check("sb_s", s, m_s);
      check("sb_changed", changed, |m_mask);
      check("sb_mask", change_mask, m_mask);
    end
  end

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    sw_raw = v ^ INV;
  endtask

  task automatic edges_to(input logic [W-1:0] v, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (s == v) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic settle(input logic [W-1:0] v);
    int n;
    drive(v);
    edges_to(v, n);
    check("settle", (n != 0), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic step(input string tag, input logic [W-1:0] v, input logic [W-1:0] mask);
    int n;
    int extra;
    drive(v);
    edges_to(v, n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_chg"}, changed, 1);
    check({tag, "_mask"}, change_mask, mask);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (changed) extra++;
    end
    check({tag, "_single"}, extra, 0);
  endtask

  initial begin
    int n;
    int bounce_chg;
    int hold [W];
    logic [W-1:0] lv;

    // Reset held 3 cycles with all switches on.
    reset  = 1'b1;
    sw_raw = 4'hF ^ INV;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      sb_en = 1'b1;
      check("rst_s", s, 0);
      check("rst_chg", changed, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    edges_to(4'hF, n);
    check("rst_lat", n, LAT);
    check("rst_chg_pulse", changed, 1);
    check("rst_mask", change_mask, 4'hF);
    @(posedge clk);
    #1;
    check("rst_chg_end", changed, 0);

    // Clean step on bit 0.
    settle(4'h0);
    step("step", 4'h1, 4'h1);

    // Bounce on bit 2: 5 high / 3 low for 40 cycles, then low.
    bounce_chg = 0;
    for (int c = 0; c < 60; c++) begin
      drive((c < 40 && (c % 8) < 5) ? 4'h5 : 4'h1);
      @(posedge clk);
      #1;
      if (changed) bounce_chg++;
      check("bounce_s2", s[2], 0);
    end
    check("bounce_nochg", bounce_chg, 0);

    // Two bits completing together.
    settle(4'h0);
    step("simul", 4'hA, 4'hA);

    // Reset asserted on edge 6 of a pending bit-3 change.
    settle(4'h0);
    drive(4'h8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("midrst_s", s, 0);
      check("midrst_chg", changed, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    edges_to(4'h8, n);
    check("midrst_lat", n, LAT);
    check("midrst_mask", change_mask, 4'h8);

`ifdef SW_ACTIVE_LOW_EN
    // Raw pins with pull-ups: 4'hE means only bit 0 switched on.
    @(negedge clk);
    reset  = 1'b1;
    sw_raw = 4'hE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edges_to(4'h1, n);
    check("actlow_lat", n, LAT);
    check("actlow_s", s, 4'h1);
`endif

    // Random per-bit hold lengths spanning both sides of the debounce window.
    lv = '0;
    for (int b = 0; b < W; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          lv[b]   = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 14));
        end else begin
          hold[b]--;
        end
      end
      sw_raw = lv ^ INV;
      reset  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
